// File: rtl/tristate_bus_pkg.sv
// Shared encodings and helpers for the tri-state pad bus arbiter.
package tristate_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DRIVE = 2'b01,
    ST_TURN  = 2'b10
  } state_t;

  // Bits needed to hold values 0..n-1 (returns 0 for n<=1).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/tristate_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after start, wrapping.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int OW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [OW-1:0]   start,
  output logic            valid,
  output logic [OW-1:0]   idx
);

  // Walk the search order backwards so the earliest hit is the last write.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[(int'(start) + i) % NREQ]) begin
        valid = 1'b1;
        idx   = OW'((int'(start) + i) % NREQ);
      end
    end
  end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner sequencer for a shared OBUFT pad bus with a forced
// high-Z turnaround window between owners.
module tristate_bus_arbiter
  import tristate_bus_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 8,
  parameter int TURN    = 2,
  parameter int MAXHOLD = 16,
  localparam int OW     = clog2(NREQ)
) (
  input  logic                    CLK,
  input  logic                    CLR_N,
  input  logic [NREQ-1:0]         REQ,
  input  logic [NREQ*WIDTH-1:0]   DIN,
  input  logic                    GTS_IN,
  output logic [NREQ-1:0]         GNT,
  output logic [OW-1:0]           OWNER,
  output logic [WIDTH-1:0]        BUS_I,
  output logic                    BUS_T,
  output logic                    BUSY
);

  localparam int HW = clog2(MAXHOLD + 1);
  localparam int TW = (clog2(TURN) < 1) ? 1 : clog2(TURN);

  state_t          state, nxt;
  logic [OW-1:0]   rr_ptr;
  logic [HW-1:0]   hold_cnt;
  logic [TW-1:0]   turn_cnt;
  logic            t_reg;
  logic            pick_vld;
  logic [OW-1:0]   pick_idx;
  logic            others_req;
  logic            leave_drive;
  logic            turn_done;

  rr_pick #(.NREQ(NREQ), .OW(OW)) u_pick (
    .req   (REQ),
    .start (rr_ptr),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  assign others_req  = |(REQ & ~(NREQ'(1) << OWNER));
  assign leave_drive = !REQ[OWNER] || GTS_IN ||
                       ((hold_cnt == HW'(MAXHOLD - 1)) && others_req);
  assign turn_done   = (turn_cnt == TW'(TURN - 1));

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) state <= ST_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:  if (!GTS_IN && pick_vld) nxt = ST_DRIVE;
      ST_DRIVE: if (leave_drive)         nxt = ST_TURN;
      ST_TURN:  if (turn_done)           nxt = ST_IDLE;
      default:                           nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      GNT      <= '0;
      OWNER    <= '0;
      BUS_I    <= '0;
      t_reg    <= 1'b1;
      rr_ptr   <= '0;
      hold_cnt <= '0;
      turn_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: if (nxt == ST_DRIVE) begin
          GNT      <= NREQ'(1) << pick_idx;
          OWNER    <= pick_idx;
          BUS_I    <= DIN[pick_idx*WIDTH +: WIDTH];
          t_reg    <= 1'b0;
          hold_cnt <= '0;
          rr_ptr   <= (pick_idx == OW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
        end
        ST_DRIVE: if (leave_drive) begin
          // BUS_I deliberately left alone: pads are going high-Z anyway.
          GNT      <= '0;
          t_reg    <= 1'b1;
          turn_cnt <= '0;
        end else begin
          BUS_I    <= DIN[OWNER*WIDTH +: WIDTH];
          if (hold_cnt != HW'(MAXHOLD)) hold_cnt <= hold_cnt + 1'b1;
        end
        ST_TURN:  turn_cnt <= turn_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  // GTS_IN bypasses the register so a global tri-state lands this cycle.
  assign BUS_T = t_reg | GTS_IN;
  assign BUSY  = (state != ST_IDLE);

endmodule
